// File: rtl/alu_result_stage.sv
// Registered FWFT result FIFO behind the ALU. It also holds the carry flag fed back to the ALU and a sticky overflow bit.
// Latency 1 cycle push-to-out; in_ready drops only when full and does not depend on out_ready. ALU_RESULT_STATS_EN adds zero_cnt.
module alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_out,
    input  logic [4:0]               in_flags,
    input  logic [3:0]               in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [4:0]               out_flags,
    output logic [3:0]               out_sel,
    output logic                     carry_q,
    output logic                     sticky_ovf,
    input  logic                     sticky_clr,
    output logic [$clog2(DEPTH):0]   level
`ifdef ALU_RESULT_STATS_EN
    ,
    output logic [15:0]              zero_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [4:0]        flags;
        logic [3:0]        sel;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    entry_t        head;

    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is read straight from storage; zeroed when nothing is held.
    assign head      = out_valid ? mem[rd_ptr] : '0;
    assign out_data  = head.data;
    assign out_flags = head.flags;
    assign out_sel   = head.sel;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: in_out, flags: in_flags, sel: in_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Carry tracks the most recently accepted result so chained ops see it one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q    <= 1'b0;
            sticky_ovf <= 1'b0;
        end else begin
            if (push) carry_q <= in_flags[0];
            if (push && in_flags[3])
                sticky_ovf <= 1'b1;
            else if (sticky_clr)
                sticky_ovf <= 1'b0;
        end
    end

`ifdef ALU_RESULT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt <= '0;
        end else if (push && in_flags[1]) begin
            if (sticky_clr)
                zero_cnt <= 16'd1;
            else if (zero_cnt != 16'hFFFF)
                zero_cnt <= zero_cnt + 16'd1;
        end else if (sticky_clr) begin
            zero_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage (DEPTH=4).
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_out;
    logic [4:0]  in_flags;
    logic [3:0]  in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_flags;
    logic [3:0]  out_sel;
    logic        carry_q;
    logic        sticky_ovf;
    logic        sticky_clr;
    logic [2:0]  level;
`ifdef ALU_RESULT_STATS_EN
    logic [15:0] zero_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    alu_result_stage #(.DATA_W(16), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_out     (in_out),
        .in_flags   (in_flags),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_flags  (out_flags),
        .out_sel    (out_sel),
        .carry_q    (carry_q),
        .sticky_ovf (sticky_ovf),
        .sticky_clr (sticky_clr),
        .level      (level)
`ifdef ALU_RESULT_STATS_EN
        ,
        .zero_cnt   (zero_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] f, input logic [3:0] s);
        in_valid = v;
        in_out   = d;
        in_flags = f;
        in_sel   = s;
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        sticky_clr = 1'b0;
        drive(1'b1, 16'hAAAA, 5'b01001, 4'd7);
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_carry", carry_q, 0);
        chk("rst_sticky", sticky_ovf, 0);
        chk("rst_out_data", out_data, 0);

        // Single pass
        rst_n = 1'b1;
        drive(1'b1, 16'h00D7, 5'b00000, 4'd1);
        out_ready = 1'b1;
        step();
        drive(1'b0, 16'h0000, 5'b00000, 4'd0);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 16'h00D7);
        chk("single_sel", out_sel, 1);
        chk("single_level", level, 1);
        step();
        chk("single_empty", out_valid, 0);
        chk("single_level0", level, 0);

        // Fill and backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 16'(i), 5'b00000, 4'(i));
            step();
        end
        chk("fill_level", level, 4);
        chk("fill_in_ready", in_ready, 0);
        drive(1'b1, 16'd5, 5'b00000, 4'd5);
        step();
        chk("fill_held_level", level, 4);
        chk("fill_head_stable", out_data, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("drain_data", out_data, 32'(k));
            chk("drain_sel", out_sel, 32'(k));
            step();
            if (k == 1) chk("fifth_waiting_level", level, 3);
            if (k == 2) begin
                drive(1'b0, 16'h0000, 5'b00000, 4'd0);
                chk("fifth_accepted_level", level, 3);
            end
        end
        chk("drain_level", level, 0);
        chk("drain_valid", out_valid, 0);

        // Simultaneous push/pop at level 2 across pointer wrap
        out_ready = 1'b0;
        drive(1'b1, 16'h0100, 5'b00000, 4'd0);
        step();
        drive(1'b1, 16'h0101, 5'b00000, 4'd1);
        step();
        chk("pp_level_start", level, 2);
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 16'(16'h0102 + j), 5'b00000, 4'(j + 2));
            chk("pp_head", out_data, 32'(16'h0100 + j));
            step();
            chk("pp_level", level, 2);
        end
        drive(1'b0, 16'h0000, 5'b00000, 4'd0);
        chk("pp_tail0", out_data, 16'h010A);
        step();
        chk("pp_tail1", out_data, 16'h010B);
        chk("pp_tail1_sel", out_sel, 4'd11);
        step();
        chk("pp_empty", level, 0);

        // Carry and sticky overflow
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        drive(1'b1, 16'h1D17, 5'b01001, 4'd2);
        step();
        chk("co_carry1", carry_q, 1);
        chk("co_sticky1", sticky_ovf, 1);
        chk("co_data", out_data, 16'h1D17);
        chk("co_flags", out_flags, 5'b01001);
        drive(1'b1, 16'h0000, 5'b00010, 4'd3);
        step();
        chk("co_carry0", carry_q, 0);
        chk("co_sticky_hold", sticky_ovf, 1);
        chk("co_flags_zero", out_flags, 5'b00010);
        drive(1'b1, 16'h0001, 5'b00001, 4'd4);
        step();
        drive(1'b0, 16'h0000, 5'b00000, 4'd0);
        chk("co_carry_load", carry_q, 1);
        step();
        chk("co_carry_idle_hold", carry_q, 1);
        sticky_clr = 1'b1;
        step();
        chk("co_sticky_clr", sticky_ovf, 0);
        drive(1'b1, 16'h8000, 5'b01000, 4'd5);
        step();
        drive(1'b0, 16'h0000, 5'b00000, 4'd0);
        sticky_clr = 1'b0;
        chk("co_set_wins", sticky_ovf, 1);
        chk("co_carry_after", carry_q, 0);
        step();

`ifdef ALU_RESULT_STATS_EN
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        chk("zc_cleared", zero_cnt, 0);
        for (int z = 0; z < 3; z++) begin
            drive(1'b1, 16'h0000, 5'b00010, 4'd6);
            step();
        end
        drive(1'b1, 16'h0005, 5'b00000, 4'd6);
        step();
        drive(1'b0, 16'h0000, 5'b00000, 4'd0);
        chk("zc_three", zero_cnt, 3);
        sticky_clr = 1'b1;
        step();
        chk("zc_clr", zero_cnt, 0);
        drive(1'b1, 16'h0000, 5'b00010, 4'd6);
        step();
        drive(1'b0, 16'h0000, 5'b00000, 4'd0);
        sticky_clr = 1'b0;
        chk("zc_clr_and_inc", zero_cnt, 1);
        step();
`endif

        // Reset mid-transfer discards contents
        out_ready = 1'b0;
        drive(1'b1, 16'h0042, 5'b00001, 4'd8);
        step();
        step();
        drive(1'b0, 16'h0000, 5'b00000, 4'd0);
        chk("mid_level_before", level, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_carry", carry_q, 0);
        chk("mid_rst_data", out_data, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_post_level", level, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered consumer stage directly downstream of the 16-bit ALU. It captures each ALU result with its five flags and opcode tag into a small first-word-fall-through FIFO. Results are presented to the writeback/consumer side over a valid/ready handshake. It also holds the architectural carry flag, which is fed back to the ALU carry_in, and a sticky overflow status bit.

Parameters:
DATA_W, 16, width of ALU result word.
DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  ALU result valid.
in_ready  output  1  stage can accept a result.
in_out  input  DATA_W  ALU result (ALU out).
in_flags  input  5  {parity, overflow, neg, zero, carry_out} from ALU.
in_sel  input  4  opcode tag travelling with the result.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer accepts head.
out_data  output  DATA_W  head result.
out_flags  output  5  head flags, same bit order as in_flags.
out_sel  output  4  head opcode tag.
carry_q  output  1  registered carry flag; drives ALU carry_in.
sticky_ovf  output  1  set by any accepted result with overflow=1.
sticky_clr  input  1  synchronous clear of sticky_ovf.
level  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): pointers=0, level=0, out_valid=0, carry_q=0, sticky_ovf=0. FIFO storage is not reset. Reset mid-transfer discards all entries.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (level != DEPTH). It does not depend on out_ready, so there is no pass-through when full.
- out_valid = (level != 0). out_data, out_flags and out_sel show the head entry combinationally from storage. When empty they are driven to 0.
- Latency: a result pushed at edge N is visible on out_* with out_valid=1 after edge N (1 cycle).
- Pointers wrap modulo DEPTH. level +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push and pop when level=DEPTH cannot occur because in_ready=0. Simultaneous push and pop when level=0 cannot occur because out_valid=0.
- Upstream must hold in_out/in_flags/in_sel stable while in_valid=1 and in_ready=0.
- Consumer-side stability: while out_valid=1 and out_ready=0, the out_* signals stay stable.
- carry_q: loaded with in_flags[0] on every push; otherwise holds. It updates at push time, not pop time, so back-to-back ALU ops chain carry with 1-cycle latency.
- sticky_ovf: set on push with in_flags[3]=1. Cleared on sticky_clr=1. When clear and set occur in the same cycle, set wins.
- No arithmetic is performed on data; widths pass through unchanged.

Optional Feature:
ALU_RESULT_STATS_EN
- Defined: adds output zero_cnt [15:0].
  - Increments on each push with in_flags[1]=1 and saturates at 16'hFFFF.
  - Reset to 0; cleared together with sticky_ovf by sticky_clr.
  - When clear and increment occur in the same cycle, the result is 1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with in_valid=1 -> out_valid=0, in_ready=1, level=0, carry_q=0, sticky_ovf=0. Release -> first push accepted next edge.
- Single pass: push in_out=16'h00D7, in_flags=5'b00000, in_sel=1, out_ready=1 -> next cycle out_valid=1, out_data=16'h00D7, out_sel=1. One cycle later out_valid=0, level=0.
- Fill/backpressure: out_ready=0, push 5 results 1..5 with DEPTH=4 -> in_ready=0 after the 4th and level=4; 5th held. Then out_ready=1 -> pops 1,2,3,4,5 in order, and the 5th is accepted the cycle after the first pop.
- Simultaneous push/pop at level=2 -> level stays 2 and order is preserved across the pointer wrap (run 10 continuous transfers).
- Carry/overflow: push in_out=16'h1D17 with in_flags=5'b01001 (carry_out=1, overflow=1) -> carry_q=1 and sticky_ovf=1 next cycle. Push 16'h0000 with flags 5'b00010 -> carry_q=0 and sticky_ovf stays 1. sticky_clr asserted together with an overflow push -> sticky_ovf stays 1.
- Zero tag with ALU_RESULT_STATS_EN defined: push three results with zero=1 (e.g. 25-25) -> zero_cnt=3. Then sticky_clr -> zero_cnt=0.
